// File: rtl/joy_pkg.sv
// ============================================================================
//  Module      : joy_pkg
//  Description : Shared types, direction bit positions and helpers for the
//                joystick direction filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package joy_pkg;

    typedef enum logic [1:0] {
        MODE_PASS8   = 2'd0,
        MODE_LAST4   = 2'd1,
        MODE_STICKY4 = 2'd2,
        MODE_HORZ2   = 2'd3
    } joy_mode_e;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // One-hot of the highest set bit; zero when no bit is set.
    function automatic logic [3:0] hi_onehot(input logic [3:0] bits);
        hi_onehot = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (bits[i]) hi_onehot = 4'b0001 << i;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/joy_dir_lane.sv
// ============================================================================
//  Module      : joy_dir_lane
//  Description : One player's direction path: synchroniser, debounce, SOCD
//                cancel, direction-mode mask and registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_dir_lane
    import joy_pkg::*;
#(
    parameter int DEB_TICKS = 3,
    parameter int SOCD      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ce,
    input  joy_mode_e  i_mode,
    input  joy_mode_e  i_mode_q,
    input  logic [3:0] i_dir,
    output logic [3:0] o_dir,
    output logic       o_chg
);

    localparam int c_cnt_w = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [c_cnt_w-1:0] c_deb_last =
        c_cnt_w'((DEB_TICKS > 0) ? DEB_TICKS - 1 : 0);

    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]         deb_q, deb_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [3:0]         v_q, v_d, mask_q, mask_d, dir_q, dir_d;
    logic               chg_q, chg_d;
    logic [3:0]         w_v, w_rise;

    always_comb begin
        sync1_d = i_dir;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (DEB_TICKS == 0) begin
            deb_d = sync2_q;
        end else if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (i_ce) begin
            if (cnt_q == c_deb_last) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_v = deb_q;
        if (SOCD != 0) begin
            if (deb_q[DIR_UP] && deb_q[DIR_DOWN]) begin
                w_v[DIR_UP]   = 1'b0;
                w_v[DIR_DOWN] = 1'b0;
            end
            if (deb_q[DIR_LEFT] && deb_q[DIR_RIGHT]) begin
                w_v[DIR_LEFT]  = 1'b0;
                w_v[DIR_RIGHT] = 1'b0;
            end
        end
        if (i_mode == MODE_HORZ2) begin
            w_v[DIR_UP]   = 1'b0;
            w_v[DIR_DOWN] = 1'b0;
        end
        w_rise = w_v & ~v_q;
    end

    // Later assignments win: the return-to-all-directions cases override any
    // mode-specific selection made above them.
    always_comb begin
        v_d    = w_v;
        mask_d = mask_q;
        case (i_mode)
            MODE_LAST4, MODE_HORZ2: begin
                if (w_rise != 4'b0000) mask_d = hi_onehot(w_rise);
            end
            MODE_STICKY4: begin
                if (mask_q == 4'hF && w_v != 4'b0000) mask_d = hi_onehot(w_v);
            end
            default: ;
        endcase
        if ((w_v & mask_q) == 4'b0000 || i_mode != i_mode_q || i_mode == MODE_PASS8)
            mask_d = 4'hF;
        dir_d = w_v & mask_q;
        chg_d = (dir_d != dir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            deb_q   <= 4'b0000;
            cnt_q   <= '0;
            v_q     <= 4'b0000;
            mask_q  <= 4'hF;
            dir_q   <= 4'b0000;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            chg_q   <= chg_d;
        end
    end

    assign o_dir = dir_q;
    assign o_chg = chg_q;

endmodule

`default_nettype wire

// File: rtl/joy_dir_filter.sv
// ============================================================================
//  Module      : joy_dir_filter
//  Description : Multi-player joystick direction conditioner; one lane per
//                player sharing a registered run-time direction mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_dir_filter
    import joy_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int DEB_TICKS = 3,
    parameter int SOCD      = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [1:0]           mode,
    input  logic [4*PLAYERS-1:0] dir_in,
    output logic [4*PLAYERS-1:0] dir_out,
    output logic [PLAYERS-1:0]   dir_chg
);

    logic      rst_meta_q, rst_meta_d, rst_sync_q, rst_sync_d;
    joy_mode_e mode_q, mode_d;
    joy_mode_e w_mode;

    assign w_mode = joy_mode_e'(mode);

    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
        mode_d     = w_mode;
    end

    // Reset asserts asynchronously but is released to the lanes on clk_sys.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
            mode_q     <= MODE_PASS8;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
            mode_q     <= mode_d;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
        joy_dir_lane #(
            .DEB_TICKS (DEB_TICKS),
            .SOCD      (SOCD)
        ) u_lane (
            .clk      (clk_sys),
            .rst_n    (rst_sync_q),
            .i_ce     (ce),
            .i_mode   (w_mode),
            .i_mode_q (mode_q),
            .i_dir    (dir_in[4*p +: 4]),
            .o_dir    (dir_out[4*p +: 4]),
            .o_chg    (dir_chg[p])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_joy_dir_filter.sv
// ============================================================================
//  Module      : tb_joy_dir_filter
//  Description : Directed self-checking bench for joy_dir_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_joy_dir_filter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       ce_off = 1'b0;
    logic       ce_deb;
    logic [1:0] ce_cnt = 2'd0;
    logic [7:0] din_f = 8'h00, din_s = 8'h00, din_d = 8'h00;
    logic [7:0] out_f, out_s, out_d;
    logic [1:0] chg_f, chg_s, chg_d;
    int         checks = 0, failures = 0;
    int         pulses_f0 = 0, pulses_s1 = 0, pulses_d = 0;
    int         snap;

    always #5 clk = ~clk;

    always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
    assign ce_deb = (ce_cnt == 2'd3);

    always @(negedge clk) begin
        if (chg_f[0]) pulses_f0++;
        if (chg_s[1]) pulses_s1++;
        if (chg_d != 2'b00) pulses_d++;
    end

    joy_dir_filter #(.PLAYERS(2), .DEB_TICKS(0), .SOCD(0)) u_fast (
        .clk_sys(clk), .reset_n(reset_n), .ce(ce_off), .mode(mode),
        .dir_in(din_f), .dir_out(out_f), .dir_chg(chg_f));

    joy_dir_filter #(.PLAYERS(2), .DEB_TICKS(0), .SOCD(1)) u_socd (
        .clk_sys(clk), .reset_n(reset_n), .ce(ce_off), .mode(mode),
        .dir_in(din_s), .dir_out(out_s), .dir_chg(chg_s));

    joy_dir_filter #(.PLAYERS(2), .DEB_TICKS(3), .SOCD(0)) u_deb (
        .clk_sys(clk), .reset_n(reset_n), .ce(ce_deb), .mode(mode),
        .dir_in(din_d), .dir_out(out_d), .dir_chg(chg_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_out", {24'd0, out_f}, 32'h00);
        check("rst_chg", {30'd0, chg_f}, 32'h0);
        reset_n = 1'b1;
        tick(6);

        // PASS8 latency: 2 sync + 1 debounce bypass + 1 output
        din_f = 8'h09;
        tick(3);
        check("pass8_lat3", {28'd0, out_f[3:0]}, 32'h0);
        tick(1);
        check("pass8_lat4", {28'd0, out_f[3:0]}, 32'h9);
        check("pass8_chg1", {31'd0, chg_f[0]}, 32'h1);
        check("pass8_lane1", {28'd0, out_f[7:4]}, 32'h0);
        tick(1);
        check("pass8_chg0", {31'd0, chg_f[0]}, 32'h0);

        // async reset mid-run
        din_f = 8'hFF;
        tick(6);
        check("pre_rst_ff", {24'd0, out_f}, 32'hFF);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_f}, 32'h00);
        check("async_rst_chg", {30'd0, chg_f}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check("post_rst_ff", {24'd0, out_f}, 32'hFF);

        // mode change to LAST4 while holding two bits: mask stays all-open
        din_f = 8'h09;
        tick(6);
        mode = 2'd1;
        tick(4);
        check("last4_held_both", {28'd0, out_f[3:0]}, 32'h9);

        // LAST4 last-pressed
        din_f = 8'h00;
        tick(6);
        din_f = 8'h01;
        tick(6);
        check("last4_right", {28'd0, out_f[3:0]}, 32'h1);
        din_f = 8'h09;
        tick(6);
        check("last4_add_up", {28'd0, out_f[3:0]}, 32'h8);
        snap = pulses_f0;
        din_f = 8'h01;
        tick(8);
        check("last4_rel_up", {28'd0, out_f[3:0]}, 32'h1);
        check("last4_rel_pulses", pulses_f0 - snap, 32'd2);

        // STICKY4
        din_f = 8'h00;
        tick(6);
        mode = 2'd2;
        tick(2);
        din_f = 8'h02;
        tick(6);
        check("sticky_left", {28'd0, out_f[3:0]}, 32'h2);
        din_f = 8'h0A;
        tick(6);
        check("sticky_add_up", {28'd0, out_f[3:0]}, 32'h2);
        din_f = 8'h08;
        tick(8);
        check("sticky_rel_left", {28'd0, out_f[3:0]}, 32'h8);

        // SOCD cancel in LAST4
        mode = 2'd1;
        din_s = 8'h30;
        tick(8);
        check("socd_lr_cancel", {28'd0, out_s[7:4]}, 32'h0);
        check("socd_lane0_idle", {28'd0, out_s[3:0]}, 32'h0);
        din_s = 8'h70;
        tick(8);
        check("socd_down_kept", {28'd0, out_s[7:4]}, 32'h4);

        // HORZ2 drops vertical
        din_s = 8'h00;
        tick(6);
        mode = 2'd3;
        tick(2);
        snap = pulses_s1;
        din_s = 8'h80;
        tick(8);
        check("horz2_up_out", {28'd0, out_s[7:4]}, 32'h0);
        check("horz2_up_pulses", pulses_s1 - snap, 32'd0);
        din_s = 8'h82;
        tick(8);
        check("horz2_left", {28'd0, out_s[3:0]}, 32'h2);

        // debounce with ce every 4th clock
        mode = 2'd0;
        din_d = 8'h00;
        tick(8);
        snap = pulses_d;
        din_d = 8'h24;
        tick(5);
        din_d = 8'h00;
        tick(40);
        check("deb_glitch_out", {24'd0, out_d}, 32'h00);
        check("deb_glitch_pulses", pulses_d - snap, 32'd0);
        din_d = 8'h24;
        tick(40);
        check("deb_stable", {24'd0, out_d}, 32'h24);
        din_d = 8'h20;
        tick(40);
        check("deb_lane0_rel", {28'd0, out_d[3:0]}, 32'h0);
        check("deb_lane1_hold", {28'd0, out_d[7:4]}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
